// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer and its single-step datapath.
package shift_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int CNT_W_DEF = 3;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate stage; passes d through when en=0.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] d,
   input  logic             dir,
   input  logic             rotate,
   input  logic             fill,
   input  logic             en,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] left_q;
   logic [WIDTH-1:0] right_q;
   logic             left_in;
   logic             right_in;

   // Bit entering the vacated end: wrapped-around bit for rotate, fill otherwise.
   assign left_in  = rotate ? d[WIDTH-1] : fill;
   assign right_in = rotate ? d[0]       : fill;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         if (gi == 0) begin : g_lsb
            assign left_q[gi] = left_in;
         end else begin : g_lmid
            assign left_q[gi] = d[gi-1];
         end
         if (gi == WIDTH-1) begin : g_msb
            assign right_q[gi] = right_in;
         end else begin : g_rmid
            assign right_q[gi] = d[gi+1];
         end
      end
   endgenerate

   assign q = !en ? d : ((dir == DIR_RIGHT) ? right_q : left_q);

endmodule

// File: rtl/shift_sequencer.sv
// Multi-step shift/rotate controller: loads an operand, steps the shifter
// once per clock for the requested amount, then pulses done for one cycle.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic [CNT_W-1:0] amount,
   input  logic             dir,
   input  logic             rotate,
   input  logic             fill,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   state_t           state_reg,  state_next;
   logic [CNT_W-1:0] cnt_reg,    cnt_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic             dir_reg,    dir_next;
   logic             rotate_reg, rotate_next;
   logic             fill_reg,   fill_next;
   logic             step_en;
   logic [WIDTH-1:0] step_q;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .d      (result_reg),
      .dir    (dir_reg),
      .rotate (rotate_reg),
      .fill   (fill_reg),
      .en     (step_en),
      .q      (step_q)
   );

   // State, counter, working register and latched controls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         result_reg <= '0;
         dir_reg    <= 1'b0;
         rotate_reg <= 1'b0;
         fill_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         result_reg <= result_next;
         dir_reg    <= dir_next;
         rotate_reg <= rotate_next;
         fill_reg   <= fill_next;
      end
   end

   // Next-state, datapath updates and status outputs.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      result_next = result_reg;
      dir_next    = dir_reg;
      rotate_next = rotate_reg;
      fill_next   = fill_reg;
      step_en     = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               result_next = load_val;
               dir_next    = dir;
               rotate_next = rotate;
               fill_next   = fill;
               cnt_next    = amount;
               state_next  = (amount != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            busy        = 1'b1;
            step_en     = 1'b1;
            result_next = step_q;
            // Counter is >=1 whenever SHIFT is entered; guard keeps it from wrapping.
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
            if (cnt_reg <= CNT_W'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign result = result_reg;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-step shift/rotate controller wrapped around a single-step 4-bit shifter datapath.
- Accepts an operand and a shift amount on a start strobe, then drives the shifter once per clock for the requested number of steps.
- Presents the final value with a one-cycle done pulse.
- Sits between control logic (FSM/ALU sequencer) and the shift datapath, so callers never sequence per-bit steps themselves.

Parameters:
- WIDTH, 4, operand width in bits (shifter datapath width).
- CNT_W, 3, width of the shift-amount field; maximum amount is 2^CNT_W-1 (7).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- load_val  input  WIDTH  operand captured on accepted start.
- amount  input  CNT_W  number of single-bit steps.
- dir  input  1  0 = left (toward MSB), 1 = right.
- rotate  input  1  1 = rotate, 0 = logical shift with fill.
- fill  input  1  bit inserted at vacated end when rotate=0.
- busy  output  1  high while steps are in progress (SHIFT state).
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  working register; final value at done, held until next accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, step counter=0, latched dir/rotate/fill=0. Reset mid-operation aborts immediately; no done is issued afterwards.
- Single-step shifter semantics (en=1):
  - left logical: {d[W-2:0], fill}
  - right logical: {fill, d[W-1:1]}
  - left rotate: {d[W-2:0], d[W-1]}
  - right rotate: {d[0], d[W-1:1]}
  - en=0: passes d unchanged.
- Internal shifter is combinational; result register is the only data storage.
- States are IDLE, SHIFT, DONE.
- IDLE:
  - start=1 captures load_val into result and latches dir/rotate/fill.
  - Counter loads amount.
  - Next state is SHIFT if amount!=0, else DONE.
  - start=0: stay in IDLE, all outputs hold.
- SHIFT:
  - busy=1, shifter en=1.
  - Each cycle: result <= shifter output, counter decrements.
  - When the counter reaches 1 on an edge, the final step is taken and next state is DONE.
  - Exactly amount steps are performed; the counter never wraps below 0.
- DONE:
  - done=1 for exactly one cycle, busy=0.
  - Next state is IDLE unconditionally.
- Latency: done asserted on the (amount+1)th rising edge after the edge that accepted start. amount=0 gives done on the next edge with result=load_val.
- start while in SHIFT or DONE is ignored (not queued). The caller must wait for IDLE, i.e. the cycle after done.
- Operand/control inputs are don't-care except at the accepting edge; later changes do not affect the operation in flight.
- busy and done are never high in the same cycle.

Decomposition:
- Shared package shift_pkg:
  - state enum (IDLE, SHIFT, DONE).
  - direction constants DIR_LEFT=0, DIR_RIGHT=1.
  - default WIDTH/CNT_W localparams.
- One sub-module, shift_step: purely combinational single-step shifter.
  - Ports: d, dir, rotate, fill, en → q.
  - Instantiated once in shift_sequencer; reusable by other datapaths.
- Counter and FSM stay in the top module.

Test Plan:
- load_val=4'b1001, amount=1, dir=0, rotate=1, start pulse → busy 1 cycle; done at edge 2 with result=4'b0011.
- load_val=4'b1001, amount=2, dir=0, rotate=0, fill=1 → intermediate 0011, then 0111; done at edge 3, result=4'b0111.
- load_val=4'b1001, amount=3, dir=1, rotate=1 → 1100, 0110, 0011; done at edge 4, result=4'b0011.
- load_val=4'b1111, amount=7, dir=1, rotate=0, fill=0 → result=4'b0000; done at edge 8; start re-pulsed during SHIFT is ignored (single done, no extra steps).
- amount=0, load_val=4'b1010 → no SHIFT cycles; done at edge 1, result=4'b1010, busy never high.
- rst_n low during SHIFT of a 5-step op → immediately state IDLE, result=0, busy=0; no done after release; a new start then completes normally.
